// File: rtl/audio_dac_tx.sv
// audio_dac_tx: sink for the mixer's stereo stream. Samples are queued in a
// small FIFO and shifted out MSB-first on the WM8731 DACDAT pin in I2S
// format. The codec is clock master, so BCLK/DACLRCK are synchronised in
// and used as edge events on the system clock. Frames that start with no
// queued sample send silence and are counted as underruns.
module audio_dac_tx #(
  parameter int DEPTH    = 4,
  parameter int LG_DEPTH = 2,
  parameter int SAMPLE_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_enable,
  input  logic                  in_valid,
  input  logic [2*SAMPLE_W-1:0] in_data,
  output logic                  in_ready,
  input  logic                  i_bclk,
  input  logic                  i_daclrck,
  output logic                  o_dacdat,
  output logic [LG_DEPTH:0]     o_level,
  output logic [15:0]           o_underrun
);

  localparam int                 CNT_W    = $clog2(SAMPLE_W + 1);
  localparam logic [LG_DEPTH:0]  FULL_LVL = (LG_DEPTH + 1)'(DEPTH);
  localparam logic [LG_DEPTH:0]  LVL_ONE  = (LG_DEPTH + 1)'(1);
  localparam logic [LG_DEPTH-1:0] PTR_ONE = LG_DEPTH'(1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SAMPLE_W);

  typedef enum logic [1:0] {
    IDLE,
    LEFT,
    RIGHT
  } state_t;

  // Pin synchronisers: [0],[1] are the 2-flop synchroniser, [2] is history
  logic [2:0] bclk_sr;
  logic [2:0] lrck_sr;
  logic       bclk_fall;
  logic       lrck_fall;
  logic       lrck_rise;

  // Registered run enable; gates in_ready so it is low through reset
  logic en_q;

  // FIFO storage and bookkeeping
  logic [2*SAMPLE_W-1:0] mem [DEPTH];
  logic [LG_DEPTH-1:0]   wr_ptr;
  logic [LG_DEPTH-1:0]   rd_ptr;
  logic [LG_DEPTH:0]     level_q;
  logic [2*SAMPLE_W-1:0] rd_data;
  logic                  push;
  logic                  pop;
  logic                  have_data;

  // Frame engine state
  state_t                state_q, state_d;
  logic [SAMPLE_W-1:0]   shift_q, shift_d;
  logic [SAMPLE_W-1:0]   right_q, right_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  skip_q, skip_d;
  logic                  dat_q, dat_d;
  logic                  urun_inc;
  logic [15:0]           underrun_q;

  // Shift both codec clocks through synchroniser + history stages
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      bclk_sr <= '0;
      lrck_sr <= '0;
    end else begin
      bclk_sr <= {bclk_sr[1:0], i_bclk};
      lrck_sr <= {lrck_sr[1:0], i_daclrck};
    end
  end

  assign bclk_fall = bclk_sr[2] & ~bclk_sr[1];
  assign lrck_fall = lrck_sr[2] & ~lrck_sr[1];
  assign lrck_rise = ~lrck_sr[2] & lrck_sr[1];

  // Register the enable so in_ready follows it one cycle later
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) en_q <= 1'b0;
    else          en_q <= i_enable;
  end

  assign in_ready  = en_q && (level_q != FULL_LVL);
  assign push      = in_valid && in_ready;
  assign have_data = (level_q != '0);
  assign rd_data   = mem[rd_ptr];

  // FIFO data array (contents need no reset; pointers define validity)
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // FIFO pointers and occupancy; disable flushes everything
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || !i_enable) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      level_q <= level_q + LVL_ONE;
      else if (!push && pop) level_q <= level_q - LVL_ONE;
    end
  end

  // Frame FSM next state, shifter and serial output. An LRCK edge arriving
  // together with a BCLK fall consumes that fall as the I2S delay bit, so
  // skip is only armed when no BCLK fall coincides with the channel start.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    right_d  = right_q;
    cnt_d    = cnt_q;
    skip_d   = skip_q;
    dat_d    = dat_q;
    pop      = 1'b0;
    urun_inc = 1'b0;
    if (!i_enable) begin
      state_d = IDLE;
      dat_d   = 1'b0;
      cnt_d   = '0;
      skip_d  = 1'b0;
    end else if (lrck_fall) begin
      state_d  = LEFT;
      pop      = have_data;
      urun_inc = !have_data;
      shift_d  = have_data ? rd_data[2*SAMPLE_W-1:SAMPLE_W] : '0;
      right_d  = have_data ? rd_data[SAMPLE_W-1:0] : '0;
      cnt_d    = '0;
      skip_d   = !bclk_fall;
      dat_d    = 1'b0;
    end else if (lrck_rise && state_q == LEFT) begin
      state_d = RIGHT;
      shift_d = right_q;
      cnt_d   = '0;
      skip_d  = !bclk_fall;
      dat_d   = 1'b0;
    end else if (state_q == IDLE) begin
      dat_d = 1'b0;
    end else if (bclk_fall) begin
      if (skip_q) begin
        skip_d = 1'b0;
        dat_d  = 1'b0;
      end else if (cnt_q != CNT_LAST) begin
        dat_d   = shift_q[SAMPLE_W-1];
        shift_d = shift_q << 1;
        cnt_d   = cnt_q + CNT_ONE;
      end else begin
        dat_d = 1'b0;
      end
    end
  end

  // Frame FSM and shifter registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      right_q <= '0;
      cnt_q   <= '0;
      skip_q  <= 1'b0;
      dat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      right_q <= right_d;
      cnt_q   <= cnt_d;
      skip_q  <= skip_d;
      dat_q   <= dat_d;
    end
  end

  // Saturating count of frames started with nothing to send
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)                                underrun_q <= '0;
    else if (urun_inc && underrun_q != 16'hFFFF) underrun_q <= underrun_q + 16'd1;
  end

  assign o_dacdat   = dat_q;
  assign o_level    = level_q;
  assign o_underrun = underrun_q;

endmodule

// File: tb/tb_audio_dac_tx.sv
// Bench for audio_dac_tx: drives codec-style BCLK/LRCK (48 BCLK per frame,
// LRCK switching on BCLK falls), captures DACDAT at each BCLK rise and
// compares decoded channel words against a table and a sample queue.
module tb_audio_dac_tx;

  localparam int HALF = 4;   // i_clk cycles per BCLK half period
  localparam int BPC  = 24;  // BCLKs per channel

  logic        i_clk;
  logic        i_rst_n;
  logic        i_enable;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        i_bclk;
  logic        i_daclrck;
  logic        o_dacdat;
  logic [2:0]  o_level;
  logic [15:0] o_underrun;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] q[$];
  logic [15:0] exp_urun = '0;

  typedef struct {
    logic [31:0] din;
    logic [15:0] exp_l;
    logic [15:0] exp_r;
  } vec_t;
  vec_t vecs[5];

  audio_dac_tx #(
    .DEPTH    (4),
    .LG_DEPTH (2),
    .SAMPLE_W (16)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_enable   (i_enable),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .i_bclk     (i_bclk),
    .i_daclrck  (i_daclrck),
    .o_dacdat   (o_dacdat),
    .o_level    (o_level),
    .o_underrun (o_underrun)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One 48-BCLK frame; optionally drops i_enable at bit drop_at of left channel
  task automatic run_frame(input int drop_at, output logic [15:0] l,
                           output logic [15:0] r, output logic pad_ok);
    logic s;
    l = '0;
    r = '0;
    pad_ok = 1'b1;
    for (int ch = 0; ch < 2; ch++) begin
      for (int b = 0; b < BPC; b++) begin
        i_bclk = 1'b0;
        if (b == 0) i_daclrck = (ch == 1);
        repeat (HALF) @(posedge i_clk);
        #1;
        s = o_dacdat;
        if (b >= 1 && b <= 16) begin
          if (ch == 0) l = {l[14:0], s};
          else         r = {r[14:0], s};
        end else if (s !== 1'b0) begin
          pad_ok = 1'b0;
        end
        if (ch == 0 && b == drop_at) begin
          i_enable = 1'b0;
          @(posedge i_clk);
          #1;
          check("drop_level", o_level, 0);
          check("drop_dacdat", o_dacdat, 0);
          check("drop_ready", in_ready, 0);
        end
        i_bclk = 1'b1;
        repeat (HALF) @(posedge i_clk);
        #1;
      end
    end
  endtask

  task automatic frame_check(input string nm, input logic [15:0] el, input logic [15:0] er);
    logic [15:0] l, r;
    logic ok;
    run_frame(-1, l, r, ok);
    check({nm, "_left"}, l, el);
    check({nm, "_right"}, r, er);
    check({nm, "_pad"}, ok, 1);
  endtask

  task automatic sb_frame(input string nm);
    logic [31:0] e;
    if (q.size() > 0) begin
      e = q.pop_front();
    end else begin
      e = '0;
      if (exp_urun != 16'hFFFF) exp_urun = exp_urun + 16'd1;
    end
    frame_check(nm, e[31:16], e[15:0]);
  endtask

  task automatic push_sample(input logic [31:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 1000) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    if (n >= 1000) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: got in_ready=0 expected 1");
    end else begin
      @(posedge i_clk);
      #1;
      q.push_back(d);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] l, r;
    logic        ok;
    logic [31:0] e;

    vecs[0] = '{32'h8001_7FFE, 16'h8001, 16'h7FFE};
    vecs[1] = '{32'hA5A5_0F0F, 16'hA5A5, 16'h0F0F};
    vecs[2] = '{32'h0000_FFFF, 16'h0000, 16'hFFFF};
    vecs[3] = '{32'hFFFF_0000, 16'hFFFF, 16'h0000};
    vecs[4] = '{32'h1357_9BDF, 16'h1357, 16'h9BDF};

    i_rst_n   = 1'b0;
    i_enable  = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    i_bclk    = 1'b1;
    i_daclrck = 1'b1;

    repeat (3) @(posedge i_clk);
    #1;
    check("rst_level", o_level, 0);
    check("rst_ready", in_ready, 0);
    check("rst_dacdat", o_dacdat, 0);
    check("rst_underrun", o_underrun, 0);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    check("ready_after_rst", in_ready, 1);
    repeat (4) @(posedge i_clk);
    #1;

    // Empty frames: silence and underrun counting
    for (int i = 0; i < 3; i++) sb_frame("empty");
    check("empty_underrun", o_underrun, 3);
    check("empty_level", o_level, 0);

    // Table-driven single-sample frames
    foreach (vecs[i]) begin
      push_sample(vecs[i].din);
      void'(q.pop_front());
      frame_check("vec", vecs[i].exp_l, vecs[i].exp_r);
    end
    check("vec_underrun", o_underrun, exp_urun);
    check("vec_level", o_level, 0);

    // Fill the FIFO, then hold a fifth sample across the next frame start
    push_sample(32'hA5A5_0001);
    push_sample(32'h5A5A_0002);
    push_sample(32'hC3C3_0003);
    push_sample(32'h3C3C_0004);
    check("full_level", o_level, 4);
    check("full_ready", in_ready, 0);
    fork
      sb_frame("fillA");
      begin
        int n = 0;
        in_valid = 1'b1;
        in_data  = 32'hF00F_0005;
        while (o_level != 3'd3 && n < 2000) begin
          if (in_ready !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL hold_ready_early: got %b expected 0", in_ready);
          end
          @(posedge i_clk);
          #1;
          n++;
        end
        check("hold_pop_seen", n < 2000, 1);
        check("hold_ready_after_pop", in_ready, 1);
        @(posedge i_clk);
        #1;
        q.push_back(32'hF00F_0005);
        in_valid = 1'b0;
        check("hold_level_refill", o_level, 4);
      end
    join
    for (int i = 0; i < 4; i++) begin
      sb_frame("order");
      check("order_level", o_level, q.size());
    end

    // Disable mid-left with two samples still queued
    push_sample(32'hFFFF_0001);
    push_sample(32'h0F0F_0002);
    push_sample(32'hF0F0_0003);
    e = q.pop_front();
    run_frame(5, l, r, ok);
    check("drop_bits_before", l[15:11], 5'b11111);
    q.delete();
    check("drop_level_after", o_level, 0);
    check("drop_underrun_held", o_underrun, exp_urun);
    i_enable = 1'b1;
    @(posedge i_clk);
    #1;
    check("reenable_ready", in_ready, 1);
    push_sample(32'h1234_5678);
    sb_frame("reenable");

    // Saturation: preload the counter near full, then run empty frames
    force dut.underrun_q = 16'hFFFD;
    @(posedge i_clk);
    #1;
    release dut.underrun_q;
    exp_urun = 16'hFFFD;
    check("sat_preload", o_underrun, exp_urun);
    for (int i = 0; i < 3; i++) begin
      sb_frame("sat");
      check("sat_underrun", o_underrun, exp_urun);
    end
    check("sat_final", o_underrun, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
